aer_receiver: RTL
=================

# aer_receiver

Receiver end of the four-phase AER link: accepts address events from an arbitrated sender (mutual-exclusion grant tree plus encoder), completes the req/ack handshake, and buffers each captured address in a small FIFO for the clocked fabric. It sits at the boundary between the asynchronous AER bus and the synchronous event-processing logic. It applies backpressure by withholding ack, so it never drops an event.

## Interface
- ADDR_W, 8, width of the AER address bus
- SYNC_STAGES, 2, flip-flops in the req synchronizer, minimum 2
- FIFO_DEPTH, 4, event FIFO entries, power of two, minimum 2
- clk  in  1  system clock; the only clock in the block
- rst  in  1  reset, asynchronous and active-high
- aer_req  in  1  sender request, asynchronous, active-high
- aer_addr  in  ADDR_W  event address; bundled data, stable from before aer_req rises until aer_ack rises
- aer_ack  out  1  acknowledge to sender, registered, active-high
- ev_valid  out  1  FIFO non-empty; ev_addr is valid
- ev_addr  out  ADDR_W  head-of-FIFO address
- ev_ready  in  1  consumer pops the head when ev_valid is also high
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
- stall  out  1  high while a synchronized request waits on a full FIFO

## Operation
- aer_req passes through SYNC_STAGES flops, all reset to 0, to produce req_s. aer_addr is never synchronized; it is sampled only when req_s is high and the FSM is in IDLE or HOLD (bundled-data guarantee).
- FSM states: INIT, IDLE, HOLD, ACK, DRAIN.
- INIT: entered on reset. Stays for SYNC_STAGES cycles, counted, to flush the synchronizer. Then goes to DRAIN if req_s=1, otherwise to IDLE. This absorbs a handshake interrupted by reset; that stale event is acked but not recorded.
- IDLE: if req_s=1 and the FIFO is not full, write aer_addr and go to ACK. If req_s=1 and the FIFO is full, go to HOLD.
- HOLD: stall=1 and aer_ack stays 0. When the FIFO is not full, write aer_addr and go to ACK.
- ACK: aer_ack=1. When req_s=0, go to IDLE, and aer_ack falls on the same edge.
- DRAIN: aer_ack=1 with no FIFO write. When req_s=0, go to IDLE.
- FIFO:
  - Occupancy updates as level + write − pop.
  - A simultaneous write and pop with a full FIFO is legal: the pop frees the slot in the same cycle, so a write in IDLE or HOLD may proceed when level=FIFO_DEPTH and the pop is active.
  - A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; level cannot exceed FIFO_DEPTH.
- The sender is assumed to obey four-phase rules. If req falls before ack rises, the event is still captured if it was already sampled in IDLE or HOLD. Otherwise it is lost with no side effect.

## Timing
- Reset values: aer_ack=0, ev_valid=0, ev_addr=0, fifo_level=0, stall=0, state=INIT, synchronizer=0.
- req→ack latency is SYNC_STAGES+1 clk edges after the first edge that samples aer_req high, with the FIFO not full.
- ack release: aer_ack falls SYNC_STAGES+1 edges after aer_req falls.
- Write→ev_valid: ev_valid and the new ev_addr appear on the edge that performs the write if the FIFO was empty, i.e. the same edge on which aer_ack rises.
- The FIFO read is first-word-fall-through: ev_addr shows the head combinationally from registered storage; a pop advances it on the next edge.
- The minimum handshake period is 2·(SYNC_STAGES+1) cycles plus sender delays.
- stall asserts one edge after HOLD is entered and deasserts on the edge that leaves HOLD.

## Structure
- Shared package aer_pkg holds:
  - the FSM state enum (INIT, IDLE, HOLD, ACK, DRAIN);
  - the default ADDR_W;
  - a function for the level width. The sender side reuses the ADDR_W default from the same package.
- Sub-module aer_event_fifo is the synchronous FWFT FIFO with parameters ADDR_W and FIFO_DEPTH, plus wr_en, rd_en, full, empty and level.
- The synchronizer is inline flops, not a separate module.

## Test plan
- Reset release with aer_req=0 → state reaches IDLE after 2 cycles; all outputs stay 0.
- Single event, addr 0x5A, ev_ready=0 → aer_ack rises 3 edges after req is sampled, ev_valid=1, ev_addr=0x5A, fifo_level=1. Then req falls → ack falls 3 edges later.
- Five back-to-back events 0x01..0x05 with ev_ready=0 and depth 4 → events 1–4 acked. Event 5 gives stall=1 and ack=0 until one pop; then ack rises, and the pops read 0x01..0x05 in order.
- Full FIFO with ev_ready=1 and req arriving on the same cycle → write and pop together, fifo_level stays 4, no HOLD entry.
- Reset asserted mid-handshake (ack=1, req held high) → ack=0 immediately. After INIT the FSM enters DRAIN with ack=1, and fifo_level stays 0 through req release.
- Pop with the FIFO empty (ev_ready=1, ev_valid=0) → fifo_level stays 0 and the pointers are unchanged.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared definitions for both ends of the AER link: receiver FSM encoding,
// default address width and the FIFO occupancy width helper.
package aer_pkg;

  localparam int unsigned AER_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4
  } aer_state_e;

  // Occupancy must represent 0..depth inclusive, hence one bit beyond the pointer.
  function automatic int unsigned aer_level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// First-word-fall-through event FIFO. The head entry is visible on rd_data_o
// straight from storage; a write into a full FIFO is accepted when a pop frees the slot.
module aer_event_fifo #(
  parameter int unsigned ADDR_W     = aer_pkg::AER_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr_en_i,
  input  logic [ADDR_W-1:0]                            wr_data_i,
  input  logic                                         rd_en_i,
  output logic [ADDR_W-1:0]                            rd_data_o,
  output logic                                         full_o,
  output logic                                         empty_o,
  output logic [aer_pkg::aer_level_w(FIFO_DEPTH)-1:0]  level_o
);
  import aer_pkg::*;

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned      LVL_W    = aer_level_w(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              rd_s;
  logic              wr_s;
  logic              full_s;
  logic              empty_s;

  assign full_s    = (level_q == LVL_FULL);
  assign empty_s   = (level_q == '0);
  assign rd_s      = rd_en_i && !empty_s;
  assign wr_s      = wr_en_i && (!full_s || rd_s);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_s;
  assign empty_o   = empty_s;
  assign level_o   = level_q;

  // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, rd_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/aer_receiver.sv
// Receiver end of a four-phase AER link: synchronizes req, captures the bundled
// address into the event FIFO and withholds ack while the FIFO cannot accept it.
module aer_receiver #(
  parameter int unsigned ADDR_W      = aer_pkg::AER_ADDR_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         aer_req,
  input  logic [ADDR_W-1:0]                            aer_addr,
  output logic                                         aer_ack,
  output logic                                         ev_valid,
  output logic [ADDR_W-1:0]                            ev_addr,
  input  logic                                         ev_ready,
  output logic [aer_pkg::aer_level_w(FIFO_DEPTH)-1:0]  fifo_level,
  output logic                                         stall
);
  import aer_pkg::*;

  localparam int unsigned      LVL_W    = aer_level_w(FIFO_DEPTH);
  localparam int unsigned      CNT_W    = $clog2(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_early_s;
  aer_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic                   stall_q, stall_d;
  logic                   wr_en_s;
  logic                   pop_s;
  logic                   can_write_s;
  logic                   full_s;
  logic                   empty_s;
  logic [LVL_W-1:0]       level_s;

  assign req_s       = sync_q[SYNC_STAGES-1];
  // Value req_s takes on the next edge; lets INIT decide on its final cycle.
  assign req_early_s = sync_q[SYNC_STAGES-2];
  assign pop_s       = ev_ready && !empty_s;
  assign can_write_s = !full_s || pop_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], aer_req};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = req_early_s ? ST_DRAIN : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (req_s) begin
          state_d = can_write_s ? ST_ACK : ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end else if (can_write_s) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_ACK, ST_DRAIN: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // ack and stall are registered from the upcoming state so they move on the transition edge.
  always_comb begin
    wr_en_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: wr_en_s = req_s && can_write_s;
      default:          wr_en_s = 1'b0;
    endcase
    ack_d   = (state_d == ST_ACK) || (state_d == ST_DRAIN);
    stall_d = (state_q == ST_HOLD) && (state_d == ST_HOLD);
  end

  aer_event_fifo #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_s),
    .wr_data_i (aer_addr),
    .rd_en_i   (ev_ready),
    .rd_data_o (ev_addr),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .level_o   (level_s)
  );

  assign aer_ack    = ack_q;
  assign stall      = stall_q;
  assign ev_valid   = !empty_s;
  assign fifo_level = level_s;

endmodule
